// File: rtl/issue_queue_int_pkg.sv
// Shared widths for the integer issue queue and its oldest-ready selector.
package issue_queue_int_pkg;

  localparam int unsigned IQ_DEPTH  = 4;
  localparam int unsigned IQ_TAG_W  = 6;
  localparam int unsigned IQ_DATA_W = 32;
  localparam int unsigned IQ_INST_W = 32;

endpackage

// File: rtl/iq_oldest_ready_sel.sv
// Priority picker: lowest-index set bit of req wins (slot 0 is the oldest entry).
module iq_oldest_ready_sel #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan from the youngest down so the oldest requester is the last writer.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_c    = '0;
        grant_c[i] = 1'b1;
        idx_c      = IDX_W'(i);
        any_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_int.sv
// Integer-ALU issue queue: shifting, oldest-first, with CDB wakeup and dispatch-time bypass.
module issue_queue_int
  import issue_queue_int_pkg::*;
#(
  parameter int unsigned DEPTH  = IQ_DEPTH,
  parameter int unsigned TAG_W  = IQ_TAG_W,
  parameter int unsigned DATA_W = IQ_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 equeueint_en,
  output logic                 equeueint_ready,
  input  logic [IQ_INST_W-1:0] equeue_inst,
  input  logic                 equeue_rsvalid,
  input  logic [DATA_W-1:0]    equeue_rsdata,
  input  logic [TAG_W-1:0]     equeue_rstag,
  input  logic                 equeue_rtvalid,
  input  logic [DATA_W-1:0]    equeue_rtdata,
  input  logic [TAG_W-1:0]     equeue_rttag,
  input  logic [TAG_W-1:0]     equeue_rdtag,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [IQ_INST_W-1:0] issue_inst,
  output logic [DATA_W-1:0]    issue_rsdata,
  output logic [DATA_W-1:0]    issue_rtdata,
  output logic [TAG_W-1:0]     issue_rdtag
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [DEPTH-1:0]     rsv_q, rsv_d, rtv_q, rtv_d;
  logic [IQ_INST_W-1:0] inst_q  [DEPTH];
  logic [IQ_INST_W-1:0] inst_d  [DEPTH];
  logic [DATA_W-1:0]    rsd_q   [DEPTH];
  logic [DATA_W-1:0]    rsd_d   [DEPTH];
  logic [DATA_W-1:0]    rtd_q   [DEPTH];
  logic [DATA_W-1:0]    rtd_d   [DEPTH];
  logic [TAG_W-1:0]     rstag_q [DEPTH];
  logic [TAG_W-1:0]     rstag_d [DEPTH];
  logic [TAG_W-1:0]     rttag_q [DEPTH];
  logic [TAG_W-1:0]     rttag_d [DEPTH];
  logic [TAG_W-1:0]     rdtag_q [DEPTH];
  logic [TAG_W-1:0]     rdtag_d [DEPTH];

  logic [DEPTH-1:0]     wk_rsv, wk_rtv;
  logic [DATA_W-1:0]    wk_rsd [DEPTH];
  logic [DATA_W-1:0]    wk_rtd [DEPTH];

  logic [DEPTH-1:0]     rdy_vec, grant;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_any;
  logic [CNT_W-1:0]     count, wslot;
  logic                 fire, wr_en;
  logic                 in_rsv, in_rtv;
  logic [DATA_W-1:0]    in_rsd, in_rtd;

  // Eligibility uses registered operand state only: a wakeup issues no earlier than the next cycle.
  assign rdy_vec = vld_q & rsv_q & rtv_q;

  iq_oldest_ready_sel #(.DEPTH(DEPTH)) u_sel (
    .req     (rdy_vec),
    .grant_c (grant),
    .idx_c   (sel_idx),
    .any_c   (sel_any)
  );

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(vld_q[i]);
  end

  assign equeueint_ready = (count < CNT_W'(DEPTH));
  assign issue_valid     = sel_any;
  assign fire            = sel_any && issue_ready;
  assign wr_en           = equeueint_en && equeueint_ready;
  assign wslot           = count - CNT_W'(fire);

  // One-hot AND-OR mux; grant is all-zero when nothing is eligible, so outputs fall to 0.
  always_comb begin
    issue_inst   = '0;
    issue_rsdata = '0;
    issue_rtdata = '0;
    issue_rdtag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_inst   = issue_inst   | inst_q[i];
        issue_rsdata = issue_rsdata | rsd_q[i];
        issue_rtdata = issue_rtdata | rtd_q[i];
        issue_rdtag  = issue_rdtag  | rdtag_q[i];
      end
    end
  end

  // CDB snoop applied to every stored entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk_rsv[i] = rsv_q[i];
      wk_rsd[i] = rsd_q[i];
      wk_rtv[i] = rtv_q[i];
      wk_rtd[i] = rtd_q[i];
      if (!rsv_q[i] && cdb_valid && (rstag_q[i] == cdb_tag)) begin
        wk_rsv[i] = 1'b1;
        wk_rsd[i] = cdb_data;
      end
      if (!rtv_q[i] && cdb_valid && (rttag_q[i] == cdb_tag)) begin
        wk_rtv[i] = 1'b1;
        wk_rtd[i] = cdb_data;
      end
    end
  end

  // Dispatch bypass for an operand produced on the CDB in the same cycle.
  always_comb begin
    in_rsv = equeue_rsvalid;
    in_rsd = equeue_rsdata;
    in_rtv = equeue_rtvalid;
    in_rtd = equeue_rtdata;
    if (!equeue_rsvalid && cdb_valid && (equeue_rstag == cdb_tag)) begin
      in_rsv = 1'b1;
      in_rsd = cdb_data;
    end
    if (!equeue_rtvalid && cdb_valid && (equeue_rttag == cdb_tag)) begin
      in_rtv = 1'b1;
      in_rtd = cdb_data;
    end
  end

  // Next state: hold (with wakeup), collapse above the issued slot, append, then flush.
  always_comb begin
    vld_d = vld_q;
    rsv_d = wk_rsv;
    rtv_d = wk_rtv;
    for (int i = 0; i < DEPTH; i++) begin
      inst_d[i]  = inst_q[i];
      rsd_d[i]   = wk_rsd[i];
      rtd_d[i]   = wk_rtd[i];
      rstag_d[i] = rstag_q[i];
      rttag_d[i] = rttag_q[i];
      rdtag_d[i] = rdtag_q[i];
    end
    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          vld_d[i]   = vld_q[i+1];
          rsv_d[i]   = wk_rsv[i+1];
          rtv_d[i]   = wk_rtv[i+1];
          inst_d[i]  = inst_q[i+1];
          rsd_d[i]   = wk_rsd[i+1];
          rtd_d[i]   = wk_rtd[i+1];
          rstag_d[i] = rstag_q[i+1];
          rttag_d[i] = rttag_q[i+1];
          rdtag_d[i] = rdtag_q[i+1];
        end
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wslot) begin
          vld_d[i]   = 1'b1;
          rsv_d[i]   = in_rsv;
          rtv_d[i]   = in_rtv;
          inst_d[i]  = equeue_inst;
          rsd_d[i]   = in_rsd;
          rtd_d[i]   = in_rtd;
          rstag_d[i] = equeue_rstag;
          rttag_d[i] = equeue_rttag;
          rdtag_d[i] = equeue_rdtag;
        end
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      rsv_q <= '0;
      rtv_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]  <= '0;
        rsd_q[i]   <= '0;
        rtd_q[i]   <= '0;
        rstag_q[i] <= '0;
        rttag_q[i] <= '0;
        rdtag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      rsv_q <= rsv_d;
      rtv_q <= rtv_d;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]  <= inst_d[i];
        rsd_q[i]   <= rsd_d[i];
        rtd_q[i]   <= rtd_d[i];
        rstag_q[i] <= rstag_d[i];
        rttag_q[i] <= rttag_d[i];
        rdtag_q[i] <= rdtag_d[i];
      end
    end
  end

endmodule
